// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - multi-cycle MIPS multiply/divide unit owning HI/LO
//
// Purpose: executes MULT, MULTU, DIV, DIVU (one result bit per enabled cycle)
// and MTHI/MTLO, and holds the HI/LO architectural registers.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   clk_enable      - when low every register holds
//   start, op       - request strobe and opcode (0 MULT, 1 MULTU, 2 DIV,
//                     3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op)
//   rs_data/rt_data - operand A / operand B
//   mf_req          - core is issuing MFHI/MFLO
//   busy, done      - operation in progress / one-cycle completion pulse
//   stall           - mf_req & busy
//   hi, lo          - HI and LO registers
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Multiply: {partial product high half, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             done_q, done_d;

  // Operand conditioning: signed ops (MULT, DIV) work on magnitudes.
  logic             signed_op, neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign signed_op = ~op[0];
  assign neg_a     = signed_op & rs_data[WIDTH-1];
  assign neg_b     = signed_op & rt_data[WIDTH-1];
  assign abs_a     = neg_a ? -rs_data : rs_data;
  assign abs_b     = neg_b ? -rt_data : rt_data;

  // One shift-add step; the extra bit catches the carry of the add.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);

  // One restoring-division step. The remainder is always below the divisor,
  // so the shifted value fits in WIDTH+1 bits and the kept value in WIDTH.
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ge;
  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift - {1'b0, opb_q};

  // Sign correction applied on the FINISH edge.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, quo_mag, rem_mag;
  assign quo_mag  = acc_q[WIDTH-1:0];
  assign rem_mag  = acc_q[W2-1:WIDTH];
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  // A zero divisor leaves the remainder equal to |dividend|, so the normal
  // remainder sign fix restores the original dividend; only LO is forced.
  assign quo_fix  = (opb_q == '0) ? '1 : (neg_res_q ? -quo_mag : quo_mag);
  assign rem_fix  = neg_rem_q ? -rem_mag : rem_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!op[2]) begin
            opa_d     = abs_a;
            opb_d     = abs_b;
            is_div_d  = op[1];
            neg_res_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            acc_d     = op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            cnt_d     = CNT_W'(WIDTH - 1);
            state_d   = ST_RUN;
          end else if (op[1:0] == 2'b00) begin
            hi_d = rs_data;
          end else if (op[1:0] == 2'b01) begin
            lo_d = rs_data;
          end
        end
      end
      ST_RUN: begin
        if (is_div_q) begin
          acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FINISH: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign stall = mf_req & busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - self-checking bench for mips_muldiv_unit
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        mf_req = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  logic        ce8 = 1'b1;
  logic        start8 = 1'b0;
  logic [2:0]  op8 = 3'd7;
  logic [7:0]  rs8 = '0;
  logic [7:0]  rt8 = '0;
  logic        mf8 = 1'b0;
  logic        busy8, done8, stall8;
  logic [7:0]  hi8, lo8;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mf_req(mf_req),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .clk_enable(ce8), .start(start8), .op(op8),
    .rs_data(rs8), .rt_data(rt8), .mf_req(mf8),
    .busy(busy8), .done(done8), .stall(stall8), .hi(hi8), .lo(lo8)
  );

  // Architectural result of an op, from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Model: an accepted mul/div delivers its result WIDTH+1 enabled edges later.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_busy;
  assign m_busy = (m_left != 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else if (clk_enable) begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          m_pend <= ref_result(op, rs_data, rt_data);
          m_left <= 33;
        end else if (op == 3'd4) begin
          m_hi <= rs_data;
        end else if (op == 3'd5) begin
          m_lo <= rs_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (busy !== m_busy || done !== m_done || stall !== (mf_req & m_busy) ||
        hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t: busy %b want %b, done %b want %b, stall %b want %b, hi %h want %h, lo %h want %h",
               $time, busy, m_busy, done, m_done, stall, mf_req & m_busy, hi, m_hi, lo, m_lo);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op; return number of edges from the accept edge to done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int pause_at, input int inject_at, output int edges);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (pause_at > 0 && edges == pause_at) clk_enable = 1'b0;
      if (pause_at > 0 && edges == pause_at + 5) clk_enable = 1'b1;
      if (inject_at > 0 && edges == inject_at) begin
        op = 3'd4; rs_data = 32'h1234; start = 1'b1;
      end
      if (inject_at > 0 && edges == inject_at + 1) start = 1'b0;
      if (mf_req && edges == 5) chk("stall_mid_run", stall, 1);
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int e;
    reset = 1'b1;
    #23 reset = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, e);
    chk("multu_edges", e, 33);
    chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, e);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, e);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(3'd3, 32'd7, 32'd0, 0, 0, e);
    chk("divu_zero_hilo", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    chk("divu_zero_edges", e, 33);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, e);
    chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op(3'd2, 32'd100, 32'hFFFF_FFF9, 0, 0, e);
    chk("div_pos_neg_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFF2);

    mf_req = 1'b1;
    run_op(3'd1, 32'h0001_0000, 32'h0003_0000, 0, 4, e);
    chk("stall_done_cycle", stall, 0);
    chk("mthi_ignored_hilo", {hi, lo}, 64'h0000_0003_0000_0000);
    mf_req = 1'b0;

    @(negedge clk);
    op = 3'd5; rs_data = 32'h0000_ABCD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_ABCD);
    chk("mtlo_no_done", {busy, done}, 2'b00);

    run_op(3'd3, 32'd100, 32'd7, 10, 0, e);
    chk("pause_edges", e, 38);
    chk("pause_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    @(negedge clk);
    op = 3'd1; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_state", {busy, hi, lo}, 65'd0);
    #2 reset = 1'b0;

    @(negedge clk);
    op8 = 3'd3; rs8 = 8'd200; rt8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    e = 0;
    while (e < 50) begin
      @(posedge clk);
      e++;
      #1;
      if (done8) break;
    end
    chk("w8_edges", e, 9);
    chk("w8_hilo", {hi8, lo8}, {8'd4, 8'd28});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO registers for the MIPS CPU. It replaces the single-cycle ALU multiply/divide path and the plain HI/LO register file.
- It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, one result bit per cycle.
- It exposes busy/done status and a stall output so the core holds MFHI/MFLO until the result is valid.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be even and at least 4.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- clk_enable  input  1  when low, all state, counters, HI and LO hold
- start  input  1  request strobe, sampled on an enabled edge
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- rs_data  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source)
- rt_data  input  WIDTH  operand B (multiplier / divisor)
- mf_req  input  1  core is currently issuing MFHI or MFLO
- busy  output  1  high while a multiply/divide is in progress
- done  output  1  one-cycle pulse after HI/LO take a new mul/div result
- stall  output  1  equals mf_req & busy; combinational
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; hi, lo, counter and internal datapath are all 0.
  - busy=0, done=0.
  - Reset mid-operation aborts the operation with no partial write.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FINISH: busy=1.
- Accept rule: start is accepted only on an enabled edge in IDLE. start in RUN or FINISH is ignored and not queued.
- MTHI/MTLO: on acceptance, hi or lo takes rs_data at that edge. State stays IDLE, no done pulse.
- MULT/MULTU/DIV/DIVU on acceptance:
  - Latch operands. Signed ops latch absolute values and record sign flags.
  - counter=WIDTH-1; go to RUN.
- RUN, one iteration per enabled edge:
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
  - At counter==0, go to FINISH; otherwise decrement.
- FINISH, at the next enabled edge:
  - Apply sign correction and write hi/lo.
  - Go to IDLE; done=1 for exactly the following cycle.
- Latency:
  - Accept edge at T: busy high after T, hi/lo updated at edge T+WIDTH+1, busy low and done high after that edge.
  - Back-to-back: a new start may be accepted on the edge where done is high.
- Multiply result:
  - {hi,lo} = full 2*WIDTH product.
  - MULT is signed two's complement; the product is negated when the operand signs differ.
- Divide result:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - The quotient is negated when the signs differ.
- Divide by zero (DIV and DIVU):
  - lo = all ones, hi = dividend unchanged.
  - Still takes the full latency; no exception.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
- clk_enable low freezes the FSM and counter; done holds its value.
- hi and lo do not change during RUN; the old values stay readable until the FINISH edge.
- stall depends only on mf_req and busy. stall is low in the done cycle, so MF reads the new value.

Test Plan:
- MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF, WIDTH=32 -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles; done pulses once, 33 edges after accept.
- MULT, rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV, rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 -> hi=0x00000007, lo=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- During busy:
  - start MTHI rs=0x1234 is ignored; hi keeps the result.
  - mf_req=1 -> stall=1 until the done cycle.
  - MTLO 0xABCD when idle -> lo=0xABCD after one edge, no done pulse.
- clk_enable held low 5 cycles mid-RUN -> result and done delayed exactly 5 cycles.
  - Async reset asserted mid-RUN, between edges -> busy, hi, lo all 0 immediately.
- WIDTH=8 instance: DIVU 200/7 -> lo=28, hi=4, done 9 edges after accept.
